// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button debounce, start/stop/lap/clear FSM and count-enable prescaler
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int TICK_DIV   = 500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    output logic       CNT_EN,
    output logic       CNT_CLR,
    output logic       DISP_HOLD,
    output logic [1:0] STATE
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    // bit 0 = start/stop, bit 1 = lap/clear
    logic [1:0]         w_raw;
    logic [1:0]         r_meta;
    logic [1:0]         r_sync;
    logic [1:0]         r_stable;
    logic [1:0]         r_armed;
    logic [1:0]         r_press;
    logic [1:0]         r_warm;
    logic [1:0][DW-1:0] r_deb_cnt;

    state_t             r_state;
    logic               r_hold;
    logic               r_clr;
    logic [TW-1:0]      r_tick_cnt;
    logic               r_cnt_en;
    logic               w_ss;
    logic               w_lap;
    logic               w_counting;

    assign w_raw = {BTN_LAP, BTN_SS};
    assign w_ss  = r_press[0];
    assign w_lap = r_press[1];

    // A button is armed only once its synced level has been seen released after
    // reset, so a button held through reset cannot fire a press.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_meta    <= 2'b11;
            r_sync    <= 2'b11;
            r_stable  <= 2'b11;
            r_armed   <= 2'b00;
            r_press   <= 2'b00;
            r_warm    <= 2'd0;
            r_deb_cnt <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable[i]  <= r_sync[i];
                    r_deb_cnt[i] <= '0;
                    r_press[i]   <= ~r_sync[i] & r_armed[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
                if (r_warm == 2'd2 && r_sync[i]) begin
                    r_armed[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_hold  <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ss) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_ss) begin
                        r_state <= S_STOP;
                    end else if (w_lap) begin
                        r_state <= S_LAP;
                        r_hold  <= 1'b1;
                    end
                end
                S_LAP: begin
                    if (w_ss) begin
                        r_state <= S_STOP;
                        r_hold  <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= S_RUN;
                        r_hold  <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_ss) begin
                        r_state <= S_RUN;
                    end else if (w_lap) begin
                        r_state <= S_IDLE;
                        r_clr   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    // The cycle a stop press is consumed already counts as stopped, so no tick
    // can coincide with the first STOP cycle.
    assign w_counting = (r_state == S_RUN || r_state == S_LAP) && !w_ss;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tick_cnt <= '0;
            r_cnt_en   <= 1'b0;
        end else begin
            r_cnt_en <= 1'b0;
            if (r_state == S_IDLE) begin
                r_tick_cnt <= '0;
            end else if (w_counting) begin
                if (r_tick_cnt == TICK_LAST) begin
                    r_tick_cnt <= '0;
                    r_cnt_en   <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign STATE     = r_state;
    assign DISP_HOLD = r_hold;
    assign CNT_CLR   = r_clr;
    assign CNT_EN    = r_cnt_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed plus random button stimulus against a cycle reference model
module tb_stopwatch_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN_SS = 1'b1;
    logic       BTN_LAP = 1'b1;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic       DISP_HOLD;
    logic [1:0] STATE;

    always #10 CLK = ~CLK;

    stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut (
        .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP),
        .CNT_EN(CNT_EN), .CNT_CLR(CNT_CLR), .DISP_HOLD(DISP_HOLD), .STATE(STATE)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_tick, n_clr, gap_err, cyc_no, last_tick;
    bit saw_lap;

    // Reference model: state as 0..3, prescaler phase as a modulo count, debounce as run lengths.
    int m_state, m_ph, m_since;
    bit m_en, m_clr, m_hold;
    int m_run[2];
    bit m_stab[2], m_p1[2], m_p2[2], m_arm[2], m_prs[2];

    function automatic void model_reset();
        m_state = 0; m_ph = 0; m_since = 0;
        m_en = 0; m_clr = 0; m_hold = 0;
        for (int b = 0; b < 2; b++) begin
            m_run[b] = 0; m_stab[b] = 1; m_p1[b] = 1; m_p2[b] = 1; m_arm[b] = 0; m_prs[b] = 0;
        end
    endfunction

    function automatic void model_step();
        bit raw[2];
        bit np[2];
        bit s, active;
        raw[0] = BTN_SS;
        raw[1] = BTN_LAP;
        active = (m_state == 1 || m_state == 2) && !m_prs[0];
        m_en = active && (m_ph == TICK - 1);
        if (m_state == 0) m_ph = 0;
        else if (active) m_ph = (m_ph + 1) % TICK;
        m_clr = 0;
        case (m_state)
            0: if (m_prs[0]) m_state = 1;
            1: if (m_prs[0]) m_state = 3; else if (m_prs[1]) m_state = 2;
            2: if (m_prs[0]) m_state = 3; else if (m_prs[1]) m_state = 1;
            3: if (m_prs[0]) m_state = 1; else if (m_prs[1]) begin m_state = 0; m_clr = 1; end
            default: m_state = 0;
        endcase
        m_hold = (m_state == 2);
        for (int b = 0; b < 2; b++) begin
            s = m_p2[b];
            m_p2[b] = m_p1[b];
            m_p1[b] = raw[b];
            np[b] = 0;
            if (s != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_stab[b] = s;
                    m_run[b] = 0;
                    np[b] = (s == 0) && m_arm[b];
                end
            end else begin
                m_run[b] = 0;
            end
            if (m_since >= 2 && s) m_arm[b] = 1;
            m_prs[b] = np[b];
        end
        m_since++;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("STATE", {6'b0, STATE}, 8'(m_state));
        chk("CNT_EN", {7'b0, CNT_EN}, {7'b0, m_en});
        chk("CNT_CLR", {7'b0, CNT_CLR}, {7'b0, m_clr});
        chk("DISP_HOLD", {7'b0, DISP_HOLD}, {7'b0, m_hold});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            if (!RST) model_reset(); else model_step();
            @(negedge CLK);
            cyc_no++;
            if (CNT_EN === 1'b1) begin
                n_tick++;
                if (last_tick >= 0 && cyc_no - last_tick != TICK) gap_err++;
                last_tick = cyc_no;
            end
            if (CNT_CLR === 1'b1) n_clr++;
            if (STATE === 2'd2) saw_lap = 1;
            check_model();
        end
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int bound, input string tag, output int lat);
        lat = 0;
        while (STATE !== tgt && lat < bound) begin
            cyc(1);
            lat++;
        end
        chk(tag, {6'b0, STATE}, {6'b0, tgt});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, k, exp_first, kind;
        n_tick = 0; n_clr = 0; gap_err = 0; cyc_no = 0; last_tick = -1; saw_lap = 0;
        model_reset();

        // 1: reset
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        chk("rst_state", {6'b0, STATE}, 8'd0);
        chk("rst_cnt_en", {7'b0, CNT_EN}, 8'd0);
        chk("rst_cnt_clr", {7'b0, CNT_CLR}, 8'd0);
        chk("rst_disp_hold", {7'b0, DISP_HOLD}, 8'd0);
        cyc(50);
        chk("idle_no_tick", 8'(n_tick), 8'd0);

        // 2: bounce rejection, then a real press
        repeat (5) begin
            BTN_SS = 1'b0; cyc(3);
            BTN_SS = 1'b1; cyc(3);
        end
        chk("bounce_idle", {6'b0, STATE}, 8'd0);
        BTN_SS = 1'b0;
        wait_state(2'd1, 12, "ss_to_run", lat);
        chk("run_latency", {7'b0, (lat >= DEB + 3 && lat <= DEB + 5)}, 8'd1);
        n_tick = 0; gap_err = 0; last_tick = -1;
        cyc(20 - lat);
        BTN_SS = 1'b1;
        cyc(100 - (20 - lat));
        chk("run_ticks_10pm1", {7'b0, (n_tick >= 9 && n_tick <= 11)}, 8'd1);
        chk("run_tick_spacing", 8'(gap_err), 8'd0);

        // 3: lap view and back
        BTN_LAP = 1'b0;
        wait_state(2'd2, 12, "lap_enter", lat);
        chk("lap_hold", {7'b0, DISP_HOLD}, 8'd1);
        n_tick = 0; gap_err = 0; last_tick = -1;
        cyc(5);
        BTN_LAP = 1'b1;
        cyc(35);
        chk("lap_ticks", {7'b0, (n_tick >= 3)}, 8'd1);
        chk("lap_tick_spacing", 8'(gap_err), 8'd0);
        BTN_LAP = 1'b0;
        wait_state(2'd1, 12, "lap_exit", lat);
        chk("lap_exit_hold", {7'b0, DISP_HOLD}, 8'd0);
        cyc(5);
        BTN_LAP = 1'b1;
        cyc(10);

        // 4: stop 3 cycles after a tick, resume keeps phase, then clear
        k = 0;
        while (CNT_EN !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("tick_seen", {7'b0, CNT_EN}, 8'd1);
        cyc(3);
        BTN_SS = 1'b0;
        wait_state(2'd3, 12, "stop", lat);
        exp_first = TICK - ((3 + lat - 1) % TICK);
        n_tick = 0;
        cyc(4);
        BTN_SS = 1'b1;
        cyc(56);
        chk("stop_no_tick", 8'(n_tick), 8'd0);
        BTN_SS = 1'b0;
        wait_state(2'd1, 12, "resume", lat);
        k = 0;
        while (CNT_EN !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("resume_phase", 8'(k), 8'(exp_first));
        cyc(6);
        BTN_SS = 1'b1;
        cyc(10);
        BTN_SS = 1'b0;
        wait_state(2'd3, 12, "stop2", lat);
        cyc(3);
        BTN_SS = 1'b1;
        cyc(8);
        n_clr = 0;
        BTN_LAP = 1'b0;
        wait_state(2'd0, 12, "clear_idle", lat);
        chk("clr_first_idle", {7'b0, CNT_CLR}, 8'd1);
        cyc(1);
        chk("clr_one_cycle", {7'b0, CNT_CLR}, 8'd0);
        cyc(3);
        BTN_LAP = 1'b1;
        cyc(10);
        chk("clr_count", 8'(n_clr), 8'd1);

        // 5: simultaneous presses in RUN
        BTN_SS = 1'b0;
        wait_state(2'd1, 12, "run_again", lat);
        cyc(3);
        BTN_SS = 1'b1;
        cyc(10);
        saw_lap = 0;
        BTN_SS = 1'b0; BTN_LAP = 1'b0;
        wait_state(2'd3, 12, "both_stop", lat);
        cyc(20 - lat);
        chk("both_no_lap", {7'b0, saw_lap}, 8'd0);
        chk("both_hold", {7'b0, DISP_HOLD}, 8'd0);
        BTN_SS = 1'b1; BTN_LAP = 1'b1;
        cyc(10);
        chk("both_stays_stop", {6'b0, STATE}, 8'd3);

        // 6: async reset in LAP with ss held
        BTN_SS = 1'b0;
        wait_state(2'd1, 12, "run3", lat);
        cyc(3);
        BTN_SS = 1'b1;
        cyc(8);
        BTN_LAP = 1'b0;
        wait_state(2'd2, 12, "lap3", lat);
        cyc(3);
        BTN_LAP = 1'b1;
        cyc(8);
        BTN_SS = 1'b0;
        cyc(3);
        #5 RST = 1'b0;
        model_reset();
        #1;
        chk("async_rst_state", {6'b0, STATE}, 8'd0);
        chk("async_rst_hold", {7'b0, DISP_HOLD}, 8'd0);
        cyc(2);
        RST = 1'b1;
        cyc(30);
        chk("held_no_start", {6'b0, STATE}, 8'd0);
        BTN_SS = 1'b1;
        cyc(10);
        BTN_SS = 1'b0;
        wait_state(2'd1, 12, "fresh_press", lat);
        cyc(3);
        BTN_SS = 1'b1;
        cyc(8);

        // random bounces, presses and resets against the model
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: begin BTN_SS = 1'b0; cyc($urandom_range(1, DEB - 1)); end
                1: begin BTN_LAP = 1'b0; cyc($urandom_range(1, DEB - 1)); end
                2: begin BTN_SS = 1'b0; cyc($urandom_range(DEB + 1, DEB + 12)); end
                3: begin BTN_LAP = 1'b0; cyc($urandom_range(DEB + 1, DEB + 12)); end
                4: begin BTN_SS = 1'b0; BTN_LAP = 1'b0; cyc($urandom_range(DEB + 1, DEB + 12)); end
                5: if ($urandom_range(0, 3) == 0) begin
                       RST = 1'b0; cyc($urandom_range(1, 3)); RST = 1'b1;
                   end
                default: cyc(1);
            endcase
            BTN_SS = 1'b1; BTN_LAP = 1'b1;
            cyc($urandom_range(1, 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
